// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one RAM port between icache and dcache.
// Optional statistics counters are built only when MEM_ARBITER_STATS_EN is defined.
`default_nettype none

module mem_arbiter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic [15:0] icnt,
    output logic [15:0] dcnt,
    output logic [15:0] ccnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 0 = icache, 1 = dcache
    logic   dreq_w;

    assign dreq_w = dREN | dWEN;
    assign iload  = ramload;
    assign dload  = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = 32'd0;
        ramstore     = 32'd0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        case (state_q)
            IDLE: begin
                if (dreq_w && iREN)
                    state_d = last_grant_q ? IGRANT : DGRANT;
                else if (dreq_w)
                    state_d = DGRANT;
                else if (iREN)
                    state_d = IGRANT;
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (ramready) begin
                    dwait        = 1'b0;
                    last_grant_d = 1'b1;
                    state_d      = IDLE;
                end else if (!dreq_w) begin
                    state_d = IDLE;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (ramready) begin
                    iwait        = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = IDLE;
                end else if (!iREN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] icnt_q, dcnt_q, ccnt_q;

    // Saturating counters: hold at all-ones rather than wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icnt_q <= 16'd0;
            dcnt_q <= 16'd0;
            ccnt_q <= 16'd0;
        end else begin
            if (state_q == IGRANT && ramready && icnt_q != 16'hFFFF)
                icnt_q <= icnt_q + 16'd1;
            if (state_q == DGRANT && ramready && dcnt_q != 16'hFFFF)
                dcnt_q <= dcnt_q + 16'd1;
            if (state_q == IDLE && iREN && dreq_w && ccnt_q != 16'hFFFF)
                ccnt_q <= ccnt_q + 16'd1;
        end
    end

    assign icnt = icnt_q;
    assign dcnt = dcnt_q;
    assign ccnt = ccnt_q;
`else
    assign icnt = 16'd0;
    assign dcnt = 16'd0;
    assign ccnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
`default_nettype none

module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ramready = 1'b0;
    logic [31:0] iaddr = 32'd0, daddr = 32'd0, dstore = 32'd0, ramload = 32'd0;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [15:0] icnt, dcnt, ccnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready),
        .icnt(icnt), .dcnt(dcnt), .ccnt(ccnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset;
        nRST = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd1);
        chk("rst_cnts", {icnt, dcnt | ccnt}, 32'd0);
        step;
        nRST = 1'b1;

        // D read, ready after two grant cycles
        step;
        dREN = 1'b1; daddr = 32'h0000_0040; ramload = 32'hDEAD_BEEF; ramready = 1'b0;
        #1;
        chk("rd_idle_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rd_idle_dwait", {31'd0, dwait}, 32'd1);
        step; #1;
        chk("rd_g1_ramREN", {31'd0, ramREN}, 32'd1);
        chk("rd_g1_ramaddr", ramaddr, 32'h0000_0040);
        chk("rd_g1_dwait", {31'd0, dwait}, 32'd1);
        chk("rd_g1_dload", dload, 32'hDEAD_BEEF);
        step; #1;
        chk("rd_g2_dwait", {31'd0, dwait}, 32'd1);
        step;
        ramready = 1'b1;
        #1;
        chk("rd_done_dwait", {31'd0, dwait}, 32'd0);
        chk("rd_done_iwait", {31'd0, iwait}, 32'd1);
        chk("rd_done_dload", dload, 32'hDEAD_BEEF);
        step;
        dREN = 1'b0; ramready = 1'b0;
        #1;
        chk("rd_after_dwait", {31'd0, dwait}, 32'd1);
        chk("rd_after_ramREN", {31'd0, ramREN}, 32'd0);

        // Round-robin from reset: D, I, D, I
        pulse_reset;
        nRST = 1'b1;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h0000_0100; daddr = 32'h0000_0200; ramready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_idle_ramREN", {31'd0, ramREN}, 32'd0);
            chk("rr_idle_waits", {30'd0, iwait, dwait}, 32'd3);
            step; #1;
            chk("rr_waits", {30'd0, iwait, dwait}, (k % 2 == 0) ? 32'd2 : 32'd1);
            chk("rr_ramaddr", ramaddr, (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
            step;
        end
`ifdef MEM_ARBITER_STATS_EN
        chk("rr_ccnt", {16'd0, ccnt}, 32'd4);
        chk("rr_icnt", {16'd0, icnt}, 32'd2);
        chk("rr_dcnt", {16'd0, dcnt}, 32'd2);
`endif
        iREN = 1'b0; dREN = 1'b0; ramready = 1'b0;

        // D write wins over simultaneous read
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h0000_0080; dstore = 32'h1234_5678;
        step; #1;
        chk("wr_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("wr_ramREN", {31'd0, ramREN}, 32'd0);
        chk("wr_ramstore", ramstore, 32'h1234_5678);
        chk("wr_ramaddr", ramaddr, 32'h0000_0080);
        ramready = 1'b1;
        #1;
        chk("wr_done_dwait", {31'd0, dwait}, 32'd0);
        step;
        dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;

        // Reset mid-DGRANT clears outputs at once and last_grant back to I
        dREN = 1'b1; daddr = 32'h0000_0040;
        step; #1;
        chk("mr_ramREN_pre", {31'd0, ramREN}, 32'd1);
        pulse_reset;
        chk("mr_ramREN", {31'd0, ramREN}, 32'd0);
        chk("mr_dwait", {31'd0, dwait}, 32'd1);
        chk("mr_ramaddr", ramaddr, 32'd0);
        nRST = 1'b1;
        iREN = 1'b1; iaddr = 32'h0000_0300;
        step; #1;
        chk("mr_conflict_D", ramaddr, 32'h0000_0040);
        ramready = 1'b1;
        #1;
        chk("mr_conflict_dwait", {31'd0, dwait}, 32'd0);
        step;
        dREN = 1'b0; ramready = 1'b0;

        // I granted then dropped before ready: abort, last_grant stays D
        step; #1;
        chk("ab_ramaddr", ramaddr, 32'h0000_0300);
        chk("ab_iwait_g", {31'd0, iwait}, 32'd1);
        iREN = 1'b0;
        #1;
        chk("ab_iwait_drop", {31'd0, iwait}, 32'd1);
        step; #1;
        chk("ab_idle_ramREN", {31'd0, ramREN}, 32'd0);
        chk("ab_idle_iwait", {31'd0, iwait}, 32'd1);
`ifdef MEM_ARBITER_STATS_EN
        chk("ab_icnt", {16'd0, icnt}, 32'd0);
`endif
        iREN = 1'b1; dREN = 1'b1;
        step; #1;
        chk("ab_conflict_I", ramaddr, 32'h0000_0300);
        ramready = 1'b1;
        #1;
        chk("ab_conflict_iwait", {30'd0, iwait, dwait}, 32'd1);
        step;
        iREN = 1'b0; dREN = 1'b0; ramready = 1'b0;

        // Counter saturation, or counters tied off
`ifdef MEM_ARBITER_STATS_EN
        force dut.dcnt_q = 16'hFFFE;
        #1;
        release dut.dcnt_q;
        for (int k = 0; k < 3; k++) begin
            dREN = 1'b1;
            step;
            ramready = 1'b1;
            step;
            dREN = 1'b0; ramready = 1'b0;
        end
        #1;
        chk("sat_dcnt", {16'd0, dcnt}, 32'h0000_FFFF);
`else
        chk("off_icnt", {16'd0, icnt}, 32'd0);
        chk("off_dcnt", {16'd0, dcnt}, 32'd0);
        chk("off_ccnt", {16'd0, ccnt}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
